mac_array: RTL and testbench

MAC_ARRAY -- requirements
Module: mac_array

---
 rtl/mac_array.sv | 118 +++++++++++
 tb/tb_mac_array.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array.sv
// Weight-stationary systolic MAC array: ifmaps flow right, partial sums flow down,
// and each column's finished dot product drops out of the bottom row.
module mac_array #(
  parameter int MAC_ROW        = 16,
  parameter int MAC_COL        = 16,
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     w_prefetch_in,
  input  logic                                     w_enable_in,
  input  logic [MAC_COL-1:0][W_BITWIDTH-1:0]       w_data_in,
  input  logic                                     ifmap_start_in,
  input  logic [MAC_ROW-1:0]                       ifmap_enable_in,
  input  logic [MAC_ROW-1:0][IFMAP_BITWIDTH-1:0]   ifmap_data_in,
  output logic [MAC_COL-1:0]                       ofmap_valid_out,
  output logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0]   ofmap_data_out
);

  localparam int XPAD = OFMAP_BITWIDTH - IFMAP_BITWIDTH;
  localparam int WPAD = OFMAP_BITWIDTH - W_BITWIDTH;

  logic signed [W_BITWIDTH-1:0]     w_reg [MAC_ROW][MAC_COL];
  logic signed [IFMAP_BITWIDTH-1:0] x_reg [MAC_ROW][MAC_COL];
  logic                             x_vld [MAC_ROW][MAC_COL];
  logic signed [OFMAP_BITWIDTH-1:0] psum  [MAC_ROW][MAC_COL];
  logic [MAC_COL-1:0]               out_vld;

  logic signed [IFMAP_BITWIDTH-1:0] x_in  [MAC_ROW][MAC_COL];
  logic                             v_in  [MAC_ROW][MAC_COL];
  logic signed [OFMAP_BITWIDTH-1:0] p_in  [MAC_ROW][MAC_COL];
  logic signed [OFMAP_BITWIDTH-1:0] mac   [MAC_ROW][MAC_COL];

  // Announcement pulses carry no datapath meaning.
  logic unused_ctrl;
  assign unused_ctrl = w_prefetch_in | ifmap_start_in;

  always_comb begin
    logic signed [OFMAP_BITWIDTH-1:0] x_ext;
    logic signed [OFMAP_BITWIDTH-1:0] w_ext;
    x_ext = '0;
    w_ext = '0;
    for (int r = 0; r < MAC_ROW; r++) begin
      for (int c = 0; c < MAC_COL; c++) begin
        x_in[r][c] = '0;
        v_in[r][c] = 1'b0;
        p_in[r][c] = '0;
        mac[r][c]  = '0;
      end
    end
    for (int r = 0; r < MAC_ROW; r++) begin
      x_in[r][0] = ifmap_data_in[r];
      v_in[r][0] = ifmap_enable_in[r];
      for (int c = 1; c < MAC_COL; c++) begin
        x_in[r][c] = x_reg[r][c-1];
        v_in[r][c] = x_vld[r][c-1];
      end
    end
    for (int r = 1; r < MAC_ROW; r++) begin
      for (int c = 0; c < MAC_COL; c++) begin
        p_in[r][c] = psum[r-1][c];
      end
    end
    // Operands are sign-extended to the psum width so the product wraps like the sum.
    for (int r = 0; r < MAC_ROW; r++) begin
      for (int c = 0; c < MAC_COL; c++) begin
        x_ext     = {{XPAD{x_in[r][c][IFMAP_BITWIDTH-1]}}, x_in[r][c]};
        w_ext     = {{WPAD{w_reg[r][c][W_BITWIDTH-1]}}, w_reg[r][c]};
        mac[r][c] = p_in[r][c] + x_ext * w_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < MAC_ROW; r++) begin
        for (int c = 0; c < MAC_COL; c++) begin
          w_reg[r][c] <= '0;
          x_reg[r][c] <= '0;
          x_vld[r][c] <= 1'b0;
          psum[r][c]  <= '0;
        end
      end
      out_vld <= '0;
    end else begin
      if (w_enable_in) begin
        for (int c = 0; c < MAC_COL; c++) begin
          w_reg[0][c] <= w_data_in[c];
          for (int r = 1; r < MAC_ROW; r++) begin
            w_reg[r][c] <= w_reg[r-1][c];
          end
        end
      end
      for (int r = 0; r < MAC_ROW; r++) begin
        for (int c = 0; c < MAC_COL; c++) begin
          x_vld[r][c] <= v_in[r][c];
          if (v_in[r][c]) begin
            x_reg[r][c] <= x_in[r][c];
            psum[r][c]  <= mac[r][c];
          end
        end
      end
      for (int c = 0; c < MAC_COL; c++) begin
        out_vld[c] <= v_in[MAC_ROW-1][c];
      end
    end
  end

  always_comb begin
    ofmap_valid_out = out_vld;
    for (int c = 0; c < MAC_COL; c++) begin
      ofmap_data_out[c] = psum[MAC_ROW-1][c];
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: a dot-product model schedules every expected
// result by edge number, and one compare process checks all columns every cycle.
module tb_mac_array;

  localparam int R    = 16;
  localparam int C    = 16;
  localparam int IB   = 16;
  localparam int WB   = 8;
  localparam int OB   = 32;
  localparam int NMAX = 32;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   w_prefetch_in;
  logic                   w_enable_in;
  logic [C-1:0][WB-1:0]   w_data_in;
  logic                   ifmap_start_in;
  logic [R-1:0]           ifmap_enable_in;
  logic [R-1:0][IB-1:0]   ifmap_data_in;
  logic [C-1:0]           ofmap_valid_out;
  logic [C-1:0][OB-1:0]   ofmap_data_out;

  int errors   = 0;
  int checks   = 0;
  int edge_cnt = 0;
  int wt [C][R];
  int xd [R][NMAX];
  int exp_edge_q [C][$];
  int exp_val_q  [C][$];
  int vcount [C];

  mac_array #(
    .MAC_ROW(R), .MAC_COL(C), .IFMAP_BITWIDTH(IB), .W_BITWIDTH(WB), .OFMAP_BITWIDTH(OB)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .w_prefetch_in(w_prefetch_in),
    .w_enable_in(w_enable_in),
    .w_data_in(w_data_in),
    .ifmap_start_in(ifmap_start_in),
    .ifmap_enable_in(ifmap_enable_in),
    .ifmap_data_in(ifmap_data_in),
    .ofmap_valid_out(ofmap_valid_out),
    .ofmap_data_out(ofmap_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Dot product straight from the definition; int arithmetic wraps mod 2^32.
  function automatic int model(input int c, input int n);
    int acc;
    acc = 0;
    for (int r = 0; r < R; r++) acc += xd[r][n] * wt[c][r];
    return acc;
  endfunction

  // After edge k, a column is valid exactly when the scoreboard head is due at k.
  always @(negedge clk) begin : cmp
    logic exp_v;
    for (int c = 0; c < C; c++) begin
      exp_v = (rstn === 1'b1) && (exp_edge_q[c].size() > 0) && (exp_edge_q[c][0] == edge_cnt);
      checkOutput($sformatf("valid_c%0d_e%0d", c, edge_cnt), 32'(ofmap_valid_out[c]), 32'(exp_v));
      if (exp_v) begin
        checkOutput($sformatf("data_c%0d_e%0d", c, edge_cnt), ofmap_data_out[c], exp_val_q[c][0]);
        void'(exp_edge_q[c].pop_front());
        void'(exp_val_q[c].pop_front());
      end else if (rstn !== 1'b1) begin
        checkOutput($sformatf("rstdata_c%0d", c), ofmap_data_out[c], 32'd0);
      end
      if (ofmap_valid_out[c] === 1'b1) vcount[c]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic loadWeights();
    for (int k = 0; k < R; k++) begin
      w_prefetch_in = (k == 0);
      w_enable_in   = 1'b1;
      for (int c = 0; c < C; c++) w_data_in[c] = WB'(wt[c][R-1-k]);
      tick();
    end
    w_prefetch_in = 1'b0;
    w_enable_in   = 1'b0;
    for (int c = 0; c < C; c++) w_data_in[c] = WB'($urandom);
    tick();
  endtask

  // Row r element n goes in for edge t0+r+n; abort_at >= 0 pulls reset mid-stream.
  task automatic applyStimulus(input int n_elem, input int abort_at);
    int t0;
    int n;
    t0 = edge_cnt + 1;
    for (int c = 0; c < C; c++) begin
      vcount[c] = 0;
      for (int k = 0; k < n_elem; k++) begin
        exp_edge_q[c].push_back(t0 + R - 1 + k + c);
        exp_val_q[c].push_back(model(c, k));
      end
    end
    for (int i = 0; i < n_elem + R - 1; i++) begin
      if (i == abort_at) begin
        rstn            = 1'b0;
        ifmap_enable_in = '0;
        ifmap_start_in  = 1'b0;
        for (int c = 0; c < C; c++) begin
          exp_edge_q[c].delete();
          exp_val_q[c].delete();
        end
        #1;
        for (int c = 0; c < C; c++) begin
          checkOutput($sformatf("abort_valid_c%0d", c), 32'(ofmap_valid_out[c]), 32'd0);
          checkOutput($sformatf("abort_data_c%0d", c), ofmap_data_out[c], 32'd0);
        end
        break;
      end
      ifmap_start_in = (i == 0);
      for (int r = 0; r < R; r++) begin
        n = i - r;
        if (n >= 0 && n < n_elem) begin
          ifmap_enable_in[r] = 1'b1;
          ifmap_data_in[r]   = IB'(xd[r][n]);
        end else begin
          ifmap_enable_in[r] = 1'b0;
          ifmap_data_in[r]   = IB'($urandom);
        end
      end
      tick();
    end
    ifmap_enable_in = '0;
    ifmap_start_in  = 1'b0;
  endtask

  task automatic drain(input int expect_count);
    repeat (R + C + 4) tick();
    for (int c = 0; c < C; c++) begin
      checkOutput($sformatf("missing_c%0d", c), exp_edge_q[c].size(), 32'd0);
      checkOutput($sformatf("pulses_c%0d", c), vcount[c], expect_count);
    end
  endtask

  task automatic randomData();
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) wt[c][r] = int'($signed(WB'($urandom)));
    for (int r = 0; r < R; r++)
      for (int n = 0; n < NMAX; n++) xd[r][n] = int'($signed(IB'($urandom)));
  endtask

  initial begin
    int nlen;
    w_prefetch_in   = 1'b0;
    w_enable_in     = 1'b0;
    w_data_in       = '0;
    ifmap_start_in  = 1'b0;
    ifmap_enable_in = '0;
    ifmap_data_in   = '0;
    rstn            = 1'b1;
    for (int c = 0; c < C; c++) vcount[c] = 0;
    #1 rstn = 1'b0;
    repeat (10) tick();
    for (int c = 0; c < C; c++) begin
      checkOutput($sformatf("reset_valid_c%0d", c), 32'(ofmap_valid_out[c]), 32'd0);
      checkOutput($sformatf("reset_data_c%0d", c), ofmap_data_out[c], 32'd0);
    end
    rstn = 1'b1;
    tick();

    // Unit weights, ramp ifmap: every column sums 1..16.
    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) wt[c][r] = 1;
    for (int r = 0; r < R; r++) for (int n = 0; n < NMAX; n++) xd[r][n] = r + 1;
    checkOutput("pin_ones_c0", model(0, 0), 32'd136);
    checkOutput("pin_ones_c15", model(15, 9), 32'd136);
    loadWeights();
    applyStimulus(10, -1);
    drain(10);

    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) wt[c][r] = c;
    for (int r = 0; r < R; r++) for (int n = 0; n < NMAX; n++) xd[r][n] = 1;
    checkOutput("pin_colw_c15", model(15, 0), 32'd240);
    loadWeights();
    applyStimulus(5, -1);
    drain(5);

    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) wt[c][r] = -1;
    for (int r = 0; r < R; r++) for (int n = 0; n < NMAX; n++) xd[r][n] = 32767;
    checkOutput("pin_signed", model(3, 0), 32'hFFF80010);
    loadWeights();
    applyStimulus(4, -1);
    drain(4);

    for (int c = 0; c < C; c++) for (int r = 0; r < R; r++) wt[c][r] = r + c;
    for (int r = 0; r < R; r++) for (int n = 0; n < NMAX; n++) xd[r][n] = n;
    checkOutput("pin_ramp_c0", model(0, 9), 32'd1080);
    checkOutput("pin_ramp_c15", model(15, 9), 32'd3240);
    loadWeights();
    applyStimulus(10, -1);
    drain(10);

    for (int k = 0; k < 4; k++) begin
      randomData();
      nlen = $urandom_range(NMAX, 1);
      loadWeights();
      applyStimulus(nlen, -1);
      drain(nlen);
    end

    // Reset once results are already streaming out, then stay quiet.
    randomData();
    loadWeights();
    applyStimulus(30, 20);
    repeat (3) tick();
    rstn = 1'b1;
    for (int c = 0; c < C; c++) vcount[c] = 0;
    repeat (R + C + 4) tick();
    for (int c = 0; c < C; c++)
      checkOutput($sformatf("post_reset_pulses_c%0d", c), vcount[c], 32'd0);

    randomData();
    loadWeights();
    applyStimulus(6, -1);
    drain(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
